// File: rtl/cmos_frame_crop.sv
// Frame-qualifying crop stage: drops the partial frame at reset plus SKIP_FRAMES settling frames,
// then passes only the pixels inside the LCD window. Optional colour bars: `CROP_TEST_PATTERN_EN.
module cmos_frame_crop #(
   parameter int H_START     = 112,
   parameter int H_WIDTH     = 800,
   parameter int V_START     = 120,
   parameter int V_HEIGHT    = 480,
   parameter int SKIP_FRAMES = 10
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        vsync_i,
   input  logic        de_i,
   input  logic [15:0] pdata_i,
   input  logic        test_en,
   output logic        vsync_o,
   output logic        de_o,
   output logic [15:0] pdata_o,
   output logic        frame_start,
   output logic        short_line
);

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      SKIP    = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam logic [12:0] H_LO     = 13'(H_START);
   localparam logic [12:0] H_HI     = 13'(H_START + H_WIDTH);
   localparam logic [12:0] V_LO     = 13'(V_START);
   localparam logic [12:0] V_HI     = 13'(V_START + V_HEIGHT);
   localparam logic [12:0] SKIP_LIM = 13'(SKIP_FRAMES);
   localparam logic [11:0] CNT_MAX  = 12'hFFF;

   state_t      state_reg, state_next;
   logic [11:0] skip_cnt, skip_next;
   logic [12:0] skip_inc;
   logic [11:0] h_cnt, v_cnt;
   logic [11:0] h_eff, v_eff;
   logic        vs_d, de_d;
   logic        vs_rise, de_fall;
   logic        in_win, run_now;
   logic [15:0] pix_next;

   assign vs_rise = vsync_i & ~vs_d;
   assign de_fall = de_d & ~de_i;

   // A pixel coinciding with vs_rise is pixel 0 of line 0 of the new frame.
   assign h_eff = vs_rise ? 12'd0 : h_cnt;
   assign v_eff = vs_rise ? 12'd0 : v_cnt;

   assign in_win = ({1'b0, h_eff} >= H_LO) && ({1'b0, h_eff} < H_HI) &&
                   ({1'b0, v_eff} >= V_LO) && ({1'b0, v_eff} < V_HI) &&
                   (h_eff != CNT_MAX) && (v_eff != CNT_MAX);

   assign skip_inc = {1'b0, skip_cnt} + 13'd1;

   always_comb begin
      state_next = state_reg;
      skip_next  = skip_cnt;
      run_now    = (state_reg == RUN);
      case (state_reg)
         WAIT_VS: begin
            if (vs_rise) begin
               if (SKIP_FRAMES == 0) begin
                  state_next = RUN;
                  run_now    = 1'b1;
               end else begin
                  state_next = SKIP;
                  skip_next  = 12'd0;
               end
            end
         end
         SKIP: begin
            if (vs_rise) begin
               skip_next = skip_inc[11:0];
               if (skip_inc >= SKIP_LIM) begin
                  state_next = RUN;
                  run_now    = 1'b1;
               end
            end
         end
         RUN:     state_next = RUN;
         default: state_next = WAIT_VS;
      endcase
   end

`ifdef CROP_TEST_PATTERN_EN
   // Divide by H_WIDTH via a rounded-up reciprocal; 24 fractional bits keep it exact for any 12-bit width.
   localparam int    BAR_SHIFT = 24;
   localparam longint BAR_MUL  = ((longint'(8) <<< BAR_SHIFT) + longint'(H_WIDTH) - 1) / longint'(H_WIDTH);

   logic [11:0] bar_off;
   logic [39:0] bar_prod;
   logic [2:0]  bar_idx;
   logic [15:0] bar_rgb;

   assign bar_off  = h_eff - 12'(H_START);
   assign bar_prod = 40'(bar_off) * 40'(BAR_MUL);
   assign bar_idx  = 3'(bar_prod >> BAR_SHIFT);

   always_comb begin
      bar_rgb = 16'h0000;
      case (bar_idx)
         3'd0:    bar_rgb = 16'hFFFF;
         3'd1:    bar_rgb = 16'hFFE0;
         3'd2:    bar_rgb = 16'h07FF;
         3'd3:    bar_rgb = 16'h07E0;
         3'd4:    bar_rgb = 16'hF81F;
         3'd5:    bar_rgb = 16'hF800;
         3'd6:    bar_rgb = 16'h001F;
         default: bar_rgb = 16'h0000;
      endcase
   end

   assign pix_next = test_en ? bar_rgb : pdata_i;
`else
   logic unused_test_en;
   assign unused_test_en = test_en;
   assign pix_next       = pdata_i;
`endif

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= WAIT_VS;
         skip_cnt  <= 12'd0;
      end else begin
         state_reg <= state_next;
         skip_cnt  <= skip_next;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d  <= 1'b0;
         de_d  <= 1'b0;
         h_cnt <= 12'd0;
         v_cnt <= 12'd0;
      end else begin
         vs_d <= vsync_i;
         de_d <= de_i;
         if (vs_rise)
            h_cnt <= de_i ? 12'd1 : 12'd0;
         else if (de_fall)
            h_cnt <= 12'd0;
         else if (de_i && h_cnt != CNT_MAX)
            h_cnt <= h_cnt + 12'd1;
         if (vs_rise)
            v_cnt <= 12'd0;
         else if (de_fall && v_cnt != CNT_MAX)
            v_cnt <= v_cnt + 12'd1;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_o     <= 1'b0;
         de_o        <= 1'b0;
         pdata_o     <= 16'h0000;
         frame_start <= 1'b0;
         short_line  <= 1'b0;
      end else begin
         vsync_o     <= vsync_i;
         de_o        <= de_i & in_win & run_now;
         frame_start <= vs_rise & run_now;
         if (de_i && in_win)
            pdata_o <= pix_next;
         // On de_fall h_cnt holds the length of the line that just ended.
         if (state_reg == RUN && de_fall &&
             {1'b0, v_cnt} >= V_LO && {1'b0, v_cnt} < V_HI &&
             {1'b0, h_cnt} < H_HI)
            short_line <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cmos_frame_crop.sv
// Scoreboard bench for cmos_frame_crop: two instances (SKIP_FRAMES=1 and 0) share one stimulus stream.
module tb_cmos_frame_crop;
   localparam int HS = 2;
   localparam int HW = 4;
   localparam int VS = 1;
   localparam int VH = 2;

   logic        clk = 1'b0;
   logic        rst_n, vsync_i, de_i, test_en;
   logic [15:0] pdata_i;
   logic [1:0]  vsync_o, de_o, frame_start, short_line;
   logic [15:0] pdata_o [2];

   always #5 clk = ~clk;

   cmos_frame_crop #(.H_START(HS), .H_WIDTH(HW), .V_START(VS), .V_HEIGHT(VH), .SKIP_FRAMES(1)) u_skip1 (
      .pclk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i), .test_en(test_en),
      .vsync_o(vsync_o[0]), .de_o(de_o[0]), .pdata_o(pdata_o[0]),
      .frame_start(frame_start[0]), .short_line(short_line[0]));

   cmos_frame_crop #(.H_START(HS), .H_WIDTH(HW), .V_START(VS), .V_HEIGHT(VH), .SKIP_FRAMES(0)) u_skip0 (
      .pclk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i), .test_en(test_en),
      .vsync_o(vsync_o[1]), .de_o(de_o[1]), .pdata_o(pdata_o[1]),
      .frame_start(frame_start[1]), .short_line(short_line[1]));

   typedef struct {
      int          cyc;
      logic [15:0] d;
   } exp_t;

   exp_t        exq [2][$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          frame_idx;
   int          skip [2] = '{1, 0};
   bit          exp_short [2];
   int          exp_de [2], act_de [2], exp_fs [2], act_fs [2];
   logic        prev_vs [2];
   logic        vs_samp = 1'b0;
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      vs_samp <= vsync_i;
   end

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h required %0h (cycle %0d)", name, i, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_de_o"}, i, 32'(de_o[i]), 0);
         chk({tag, "_pdata_o"}, i, 32'(pdata_o[i]), 0);
         chk({tag, "_vsync_o"}, i, 32'(vsync_o[i]), 0);
         chk({tag, "_frame_start"}, i, 32'(frame_start[i]), 0);
         chk({tag, "_short_line"}, i, 32'(short_line[i]), 0);
      end
   endtask

   // Reference: a pixel appears one cycle later iff its frame is past the skipped ones and it lies in the window.
   task automatic drive_pixel(input int v, input int h, input logic [15:0] data);
      logic [15:0] d;
      de_i    = 1'b1;
      pdata_i = data;
      d       = data;
`ifdef CROP_TEST_PATTERN_EN
      if (test_en && h >= HS && h < HS + HW)
         d = bars[(h - HS) * 8 / HW];
`endif
      for (int i = 0; i < 2; i++) begin
         if (frame_idx >= skip[i] && h >= HS && h < HS + HW && v >= VS && v < VS + VH) begin
            exq[i].push_back('{cyc: cyc + 1, d: d});
            exp_de[i]++;
         end
      end
      step();
   endtask

   task automatic send_frame(input int lens [4], input bit rnd, input int rst_line);
      for (int i = 0; i < 2; i++) begin
         act_de[i] = 0; exp_de[i] = 0; act_fs[i] = 0; exp_fs[i] = 0;
      end
      vsync_i = 1'b1;
      frame_idx++;
      for (int i = 0; i < 2; i++)
         if (frame_idx >= skip[i]) exp_fs[i]++;
      step();
      step();
      vsync_i = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      for (int v = 0; v < 4; v++) begin
         for (int h = 0; h < lens[v]; h++) begin
            drive_pixel(v, h, rnd ? 16'($urandom) : {8'(v), 8'(h)});
            if (v == rst_line && h == 3) begin
               #2 rst_n = 1'b0;
               de_i      = 1'b0;
               frame_idx = -1;
               for (int i = 0; i < 2; i++) begin
                  exq[i].delete();
                  exp_short[i] = 1'b0;
               end
               #1 check_all_zero("async_reset");
               @(posedge clk);
               #1 rst_n = 1'b1;
               repeat (3) step();
               return;
            end
         end
         de_i = 1'b0;
         for (int i = 0; i < 2; i++)
            if (frame_idx >= skip[i] && v >= VS && v < VS + VH && lens[v] < HS + HW)
               exp_short[i] = 1'b1;
         repeat ($urandom_range(1, 3)) step();
      end
      repeat (3) step();
      for (int i = 0; i < 2; i++) begin
         chk("pending_pixels", i, 32'(exq[i].size()), 0);
         chk("de_count", i, 32'(act_de[i]), 32'(exp_de[i]));
         chk("frame_start_count", i, 32'(act_fs[i]), 32'(exp_fs[i]));
         chk("short_line", i, 32'(short_line[i]), 32'(exp_short[i]));
      end
   endtask

   // Monitor: pops the scoreboard whenever de_o is presented.
   initial begin
      prev_vs = '{1'b0, 1'b0};
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
               while (exq[i].size() > 0 && exq[i][0].cyc < cyc) begin
                  checks++;
                  errors++;
                  $display("FAIL missing_pixel dut%0d: no de_o at cycle %0d, required pdata %h",
                           i, exq[i][0].cyc, exq[i][0].d);
                  void'(exq[i].pop_front());
               end
               if (de_o[i]) begin
                  act_de[i]++;
                  if (exq[i].size() > 0 && exq[i][0].cyc == cyc) begin
                     chk("pdata", i, 32'(pdata_o[i]), 32'(exq[i][0].d));
                     void'(exq[i].pop_front());
                  end else begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_de dut%0d: de_o=1 at cycle %0d, required 0", i, cyc);
                  end
               end
               if (frame_start[i]) begin
                  act_fs[i]++;
                  chk("frame_start_align", i, {30'd0, prev_vs[i], vsync_o[i]}, 32'd1);
               end
               chk("vsync_delay", i, 32'(vsync_o[i]), 32'(vs_samp));
               prev_vs[i] = vsync_o[i];
            end
         end
      end
   end

   initial begin
      int lens [4];
      rst_n     = 1'b0;
      vsync_i   = 1'b0;
      de_i      = 1'b0;
      pdata_i   = 16'h0000;
      test_en   = 1'b0;
      frame_idx = -1;
      exp_short = '{1'b0, 1'b0};
      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Tail of a frame already in progress at release: never passed.
      for (int h = 0; h < 8; h++) drive_pixel(2, h, {8'd2, 8'(h)});
      de_i = 1'b0;
      repeat (3) step();

      send_frame('{8, 8, 8, 8}, 1'b0, -1);
      send_frame('{8, 8, 8, 8}, 1'b0, -1);
      send_frame('{8, 5, 8, 8}, 1'b0, -1);
      send_frame('{8, 8, 8, 8}, 1'b0, 1);
      send_frame('{8, 8, 8, 5}, 1'b0, -1);
      send_frame('{8, 8, 8, 8}, 1'b0, -1);

      for (int f = 0; f < 6; f++) begin
         for (int v = 0; v < 4; v++) lens[v] = $urandom_range(4, 8);
         test_en = 1'($urandom_range(0, 1));
         send_frame(lens, 1'b1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cmos_frame_crop.md
# cmos_frame_crop

Frame-qualifying crop stage between the CMOS 8→16-bit packer and the video timing/FIFO stage, in the `cmos_pclk` domain. It discards the partial frame in progress at reset and a programmable number of settling frames. It then passes only the pixels inside a rectangular window sized to the LCD, so the FIFO is never written with more than one panel frame per sensor frame. Output is registered with 1-cycle latency and keeps the RGB565 bit order of its input.

## Interface

Parameters:
- `H_START`, 112 — first passed pixel index within a line (0-based)
- `H_WIDTH`, 800 — passed pixels per line
- `V_START`, 120 — first passed line index within a frame (0-based)
- `V_HEIGHT`, 480 — passed lines per frame
- `SKIP_FRAMES`, 10 — complete frames dropped after the first frame start following reset

Ports:
- `pclk` in 1 — pixel clock; the only clock
- `rst_n` in 1 — asynchronous, active-low reset
- `vsync_i` in 1 — sensor vsync, active high; its rising edge marks frame start
- `de_i` in 1 — 16-bit pixel valid from the packer
- `pdata_i` in 16 — pixel data
- `test_en` in 1 — colour-bar select; used only when `CROP_TEST_PATTERN_EN` is defined
- `vsync_o` out 1 — `vsync_i` delayed 1 cycle
- `de_o` out 1 — cropped pixel valid
- `pdata_o` out 16 — cropped pixel data
- `frame_start` out 1 — 1-cycle pulse at each frame start while in RUN
- `short_line` out 1 — sticky error flag

## Operation

- Edge detect on registered copies `vs_d` and `de_d`:
  - `vs_rise = vsync_i & ~vs_d`
  - `de_fall = de_d & ~de_i`
- Counters (12-bit, saturating at 4095):
  - `h_cnt` is the index of the current pixel while `de_i` is high. It increments on each `de_i` cycle and clears on `de_fall` and on `vs_rise`.
  - `v_cnt` increments on `de_fall` and clears on `vs_rise`.
- State machine (2-bit):
  - WAIT_VS: reset state.
    - On `vs_rise`, go to RUN if `SKIP_FRAMES==0`.
    - Otherwise go to SKIP and set `skip_cnt=0`.
  - SKIP: on each `vs_rise`, `skip_cnt++`. When `skip_cnt` reaches `SKIP_FRAMES`, go to RUN. That `vs_rise` starts the first output frame.
  - RUN: terminal. Leaves only on reset.
- Window: `in_win = (h_cnt >= H_START) && (h_cnt < H_START+H_WIDTH) && (v_cnt >= V_START) && (v_cnt < V_START+V_HEIGHT)`. Comparisons use 13-bit sums so there is no wrap.
- Output registers:
  - `de_o <= de_i & in_win & run_now`, where `run_now` is true in RUN, or when the state transitions to RUN on this cycle's `vs_rise`.
  - `pdata_o <= pdata_i` whenever `de_i & in_win`; otherwise it holds its value.
  - `vsync_o <= vsync_i`, always.
  - `frame_start <= vs_rise & run_now`.
- Short-line check:
  - `short_line` sets on `de_fall` in RUN when the line was inside the vertical window and `h_cnt < H_START+H_WIDTH`.
  - It clears only on reset.
- Simultaneous events: a cycle with both `vs_rise` and `de_i` treats the pixel as index 0 of line 0 of the new frame.
- Lines and pixels beyond the window are dropped silently. A saturated counter keeps the pixel out of the window.

## Timing

- Reset values: all outputs 0, `pdata_o = 16'h0000`, state WAIT_VS, all counters 0.
- Latency: `de_i`/`pdata_i`/`vsync_i` at cycle t appear at t+1. There is no backpressure; a pixel is presented for exactly one cycle.
- Output rate: at most H_WIDTH consecutive `de_o` cycles per line and V_HEIGHT lines per frame.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous). After release, nothing is passed until the next `vs_rise` plus SKIP_FRAMES frames.
- `vsync_i` high at reset release is not an edge, because `vs_d` resets to 0 and tracks on the first clock. Bench note: keep `vsync_i` low through release.

## Configuration

- `CROP_TEST_PATTERN_EN` defined:
  - When `test_en=1`, `pdata_o` for passed pixels is an 8-bar RGB565 pattern. The bar index is `(h_cnt - H_START) * 8 / H_WIDTH`, computed as `(h_cnt-H_START)` scaled by a constant multiply and shift.
  - Bars in order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - `de_o`, `vsync_o` and `frame_start` are unchanged.
- Undefined: `test_en` is ignored and no pattern logic is synthesised.

## Test plan

Common bench parameters: H_START=2, H_WIDTH=4, V_START=1, V_HEIGHT=2, SKIP_FRAMES=1. Each frame has 4 lines of 8 pixels with `pdata_i` equal to `{v,h}` in bytes.

1. Reset release, then frames 0 and 1 → frame 0: `de_o` never high and `frame_start` never pulses. Frame 1: `frame_start` pulses once 1 cycle after `vs_rise`, and `de_o` pulses 8 times.
2. Frame 1 content → `pdata_o` = 0102, 0103, 0104, 0105, 0202, 0203, 0204, 0205, each 1 cycle after the matching input.
3. SKIP_FRAMES=0 → the first frame after reset is output in full, 8 pixels.
4. Line 1 of a RUN frame cut to 5 pixels → `short_line` goes to 1 and stays 1. A short line 3, outside the vertical window, on a fresh run → `short_line` stays 0.
5. `rst_n` pulsed low mid-line during RUN → all outputs go to 0 asynchronously. The next two frames are handled as in scenario 1.
6. With `CROP_TEST_PATTERN_EN`, `test_en=1`, H_WIDTH=8, H_START=0 → one line outputs FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
